// File: rtl/word_nibble_reader.sv
// word_nibble_reader: captures a 16-bit word on an accepted start and streams
// it out as four 4-bit nibbles over a valid/ready handshake.
// Optional build macro WORD_NIBBLE_READER_LSB_FIRST_EN flips the emission
// order to least-significant nibble first; default is MSB-first.
// TIMEOUT > 0 enables a stall-abort: that many consecutive SEND cycles without
// a transfer drop back to IDLE with a one-cycle err pulse.
module word_nibble_reader #(
    parameter int TIMEOUT = 0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] in,
    input  logic        start,
    output logic        busy,
    output logic [3:0]  nib_out,
    output logic        nib_valid,
    input  logic        nib_ready,
    output logic        nib_last,
    output logic        done,
    output logic        err
);

    // Counter is wide enough to hold TIMEOUT; a 1-bit stub when abort is off.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    shadow_q, shadow_d;
    logic [CW-1:0]  stall_q, stall_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           xfer;
    logic           stall_hit;
    logic [3:0]     nib_sel;

    assign xfer = (state_q == SEND) && nib_ready;

    // Abort fires on the cycle that would make the stall count reach TIMEOUT.
    if (TIMEOUT > 0) begin : g_timeout
        assign stall_hit = (state_q == SEND) && !xfer && (stall_q == CW'(TIMEOUT - 1));
    end else begin : g_no_timeout
        assign stall_hit = 1'b0;
    end

    // Pick the nibble for the current index in the configured order.
    always_comb begin
        nib_sel = 4'h0;
`ifdef WORD_NIBBLE_READER_LSB_FIRST_EN
        case (idx_q)
            2'd0: nib_sel = shadow_q[3:0];
            2'd1: nib_sel = shadow_q[7:4];
            2'd2: nib_sel = shadow_q[11:8];
            default: nib_sel = shadow_q[15:12];
        endcase
`else
        case (idx_q)
            2'd0: nib_sel = shadow_q[15:12];
            2'd1: nib_sel = shadow_q[11:8];
            2'd2: nib_sel = shadow_q[7:4];
            default: nib_sel = shadow_q[3:0];
        endcase
`endif
    end

    // Next-state: start only honoured in IDLE; a transfer beats a timeout abort.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        stall_d  = stall_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = in;
                    idx_d    = 2'd0;
                    stall_d  = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    stall_d = '0;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (stall_hit) begin
                    stall_d = '0;
                    idx_d   = 2'd0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT > 0) begin
                    stall_d = stall_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset overriding start and handshakes.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            shadow_q <= 16'h0000;
            stall_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            stall_q  <= stall_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy      = (state_q == SEND);
    assign nib_valid = busy;
    assign nib_out   = busy ? nib_sel : 4'h0;
    assign nib_last  = busy && (idx_q == 2'd3);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_word_nibble_reader.sv
// Directed self-checking bench for word_nibble_reader. Inputs change and
// outputs are checked on the falling edge; the DUT acts on the rising edge.
// A second instance with TIMEOUT=4 exercises the stall-abort path.
module tb_word_nibble_reader;

    logic        clk;
    logic        rst, start, nib_ready;
    logic [15:0] in_w;
    logic        busy, nib_valid, nib_last, done, err;
    logic [3:0]  nib_out;

    logic        rst2, start2, nib_ready2;
    logic [15:0] in_w2;
    logic        busy2, nib_valid2, nib_last2, done2, err2;
    logic [3:0]  nib_out2;

    int n_checks = 0;
    int n_fail   = 0;

    word_nibble_reader dut (
        .clock(clk), .rst(rst), .in(in_w), .start(start), .busy(busy),
        .nib_out(nib_out), .nib_valid(nib_valid), .nib_ready(nib_ready),
        .nib_last(nib_last), .done(done), .err(err)
    );

    word_nibble_reader #(.TIMEOUT(4)) dut_to (
        .clock(clk), .rst(rst2), .in(in_w2), .start(start2), .busy(busy2),
        .nib_out(nib_out2), .nib_valid(nib_valid2), .nib_ready(nib_ready2),
        .nib_last(nib_last2), .done(done2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_w = 16'hFFFF; nib_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({busy, nib_valid, nib_last, nib_out, done, err} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got busy=%b vld=%b last=%b nib=%h done=%b err=%b want all 0",
                         busy, nib_valid, nib_last, nib_out, done, err);
            end
        end
        rst = 1'b0; start = 1'b0; in_w = 16'h0000;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp [4];
`ifdef WORD_NIBBLE_READER_LSB_FIRST_EN
        exp = '{4'h3, 4'hC, 4'h5, 4'hA};
`else
        exp = '{4'hA, 4'h5, 4'hC, 4'h3};
`endif
        in_w = 16'hA5C3; start = 1'b1; nib_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; in_w = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({busy, nib_valid, done, err} !== 4'b1100) begin
                n_fail++;
                $display("FAIL basic_ctrl c%0d: got busy=%b vld=%b done=%b err=%b want 1100",
                         k, busy, nib_valid, done, err);
            end
            n_checks++;
            if (nib_out !== exp[k] || nib_last !== (k == 3)) begin
                n_fail++;
                $display("FAIL basic_nib c%0d: got %h last=%b want %h last=%b",
                         k, nib_out, nib_last, exp[k], (k == 3));
            end
            @(negedge clk);
        end
        n_checks++;
        if ({busy, nib_valid, nib_last, done} !== 4'b0001 || nib_out !== 4'h0) begin
            n_fail++;
            $display("FAIL basic_done: got busy=%b vld=%b last=%b done=%b nib=%h want 0001 nib=0",
                     busy, nib_valid, nib_last, done, nib_out);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_pulse: done got %b want 0", done);
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp [7];
        logic       rdy [7];
`ifdef WORD_NIBBLE_READER_LSB_FIRST_EN
        exp = '{4'h4, 4'h3, 4'h3, 4'h3, 4'h3, 4'h2, 4'h1};
`else
        exp = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h3, 4'h4};
`endif
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        in_w = 16'h1234; start = 1'b1; nib_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (busy !== 1'b1 || nib_out !== exp[k] || nib_last !== (k == 6)) begin
                n_fail++;
                $display("FAIL stall_nib c%0d: got busy=%b nib=%h last=%b want 1 %h %b",
                         k, busy, nib_out, nib_last, exp[k], (k == 6));
            end
            nib_ready = rdy[k];
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: got busy=%b done=%b want 0 1", busy, done);
        end
    endtask

    task automatic test_back_to_back_start();
        logic [3:0] exp [4];
`ifdef WORD_NIBBLE_READER_LSB_FIRST_EN
        exp = '{4'hF, 4'hE, 4'hE, 4'hB};
`else
        exp = '{4'hB, 4'hE, 4'hE, 4'hF};
`endif
        in_w = 16'hBEEF; start = 1'b1; nib_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (busy !== 1'b1 || nib_out !== exp[k]) begin
                n_fail++;
                $display("FAIL b2b_nib c%0d: got busy=%b nib=%h want 1 %h", k, busy, nib_out, exp[k]);
            end
            // Keep a competing start asserted with a different word on the
            // first and the final-handshake cycles.
            start = (k == 0) || (k == 3);
            in_w  = 16'h0000;
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done: got busy=%b done=%b want 0 1", busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || nib_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ignored: got busy=%b vld=%b want 0 0", busy, nib_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp [4];
`ifdef WORD_NIBBLE_READER_LSB_FIRST_EN
        exp = '{4'hA, 4'h5, 4'hA, 4'h5};
`else
        exp = '{4'h5, 4'hA, 4'h5, 4'hA};
`endif
        in_w = 16'h1234; start = 1'b1; nib_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        // Two nibbles transferred; reset with start and a handshake pending.
        rst = 1'b1; start = 1'b1; in_w = 16'h5A5A;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_checks++;
        if ({busy, nib_valid, nib_last, nib_out, done, err} !== 9'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got busy=%b vld=%b last=%b nib=%h done=%b err=%b want all 0",
                     busy, nib_valid, nib_last, nib_out, done, err);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (busy !== 1'b1 || nib_out !== exp[k] || nib_last !== (k == 3)) begin
                n_fail++;
                $display("FAIL rstmid_nib c%0d: got busy=%b nib=%h last=%b want 1 %h %b",
                         k, busy, nib_out, nib_last, exp[k], (k == 3));
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_done: done got %b want 1", done);
        end
    endtask

    task automatic test_timeout();
        rst2 = 1'b1; start2 = 1'b0; nib_ready2 = 1'b0; in_w2 = 16'h0000;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        in_w2 = 16'hABCD; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({busy2, nib_valid2, done2, err2} !== 4'b1100 || nib_out2 !== 4'hA) begin
                n_fail++;
                $display("FAIL timeout_stall c%0d: got busy=%b vld=%b done=%b err=%b nib=%h want 1100 A",
                         k, busy2, nib_valid2, done2, err2, nib_out2);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({busy2, nib_valid2, done2, err2} !== 4'b0001) begin
            n_fail++;
            $display("FAIL timeout_err: got busy=%b vld=%b done=%b err=%b want 0001",
                     busy2, nib_valid2, done2, err2);
        end
        @(negedge clk);
        n_checks++;
        if ({busy2, done2, err2} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_after: got busy=%b done=%b err=%b want 000", busy2, done2, err2);
        end
        // Transfers must clear the stall count: stall 3, move, stall 3, move...
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            nib_ready2 = ((k % 4) == 3);
            n_checks++;
            if (busy2 !== 1'b1 || err2 !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_clear c%0d: got busy=%b err=%b want 1 0", k, busy2, err2);
            end
            @(negedge clk);
        end
        nib_ready2 = 1'b0;
        n_checks++;
        if (done2 !== 1'b1 || err2 !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear_done: got done=%b err=%b want 1 0", done2, err2);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; nib_ready = 1'b0; in_w = 16'h0000;
        rst2 = 1'b1; start2 = 1'b0; nib_ready2 = 1'b0; in_w2 = 16'h0000;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back_start();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/word_nibble_reader.md
WORD_NIBBLE_READER -- requirements
Module: word_nibble_reader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 0, stall-abort limit in cycles (0 = abort disabled).
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in  input  16  parallel word to read out, sampled only on accepted start.
REQ-005 SHALL have port start  input  1  request to capture in and begin readout.
REQ-006 SHALL have port busy  output  1  high whenever not IDLE.
REQ-007 SHALL have port nib_out  output  4  current nibble.
REQ-008 SHALL have port nib_valid  output  1  nib_out valid.
REQ-009 SHALL have port nib_ready  input  1  consumer accepts nibble.
REQ-010 SHALL have port nib_last  output  1  high with the fourth nibble.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final handshake.
REQ-012 SHALL have port err  output  1  one-cycle pulse on timeout abort.

Function
REQ-013 SHALL implement states IDLE and SEND; busy = (state == SEND).
REQ-014 SHALL accept start only in IDLE; an accepted start captures in into a 16-bit shadow register, clears nibble index to 0, and enters SEND on the same edge.
REQ-015 SHALL ignore start in SEND, including the cycle of the final handshake; shadow contents are never altered mid-readout.
REQ-016 SHALL drive nib_valid=1 throughout SEND; first nibble visible the cycle after start is sampled (latency 1).
REQ-017 SHALL transfer a nibble on any edge with nib_valid & nib_ready; index increments by 1 per transfer.
REQ-018 SHALL hold nib_out, nib_last stable while nib_valid & !nib_ready.
REQ-019 SHALL emit nibbles MSB-first by default: shadow[15:12], [11:8], [7:4], [3:0] for index 0..3.
REQ-020 SHALL assert nib_last only when index == 3 and nib_valid is high.
REQ-021 SHALL, on transfer at index 3, return to IDLE and pulse done for exactly the next cycle; nib_valid low that cycle.
REQ-022 SHALL, in IDLE, drive nib_valid=0, nib_last=0, nib_out=4'h0.
REQ-023 SHALL, when TIMEOUT > 0, count consecutive SEND cycles without transfer; counter clears on each transfer and on entering SEND.
REQ-024 SHALL, when the stall count reaches TIMEOUT, return to IDLE, pulse err for one cycle, and not pulse done.
REQ-025 SHALL never assert done and err in the same cycle; a transfer on the timeout cycle takes priority (no abort).

Reset
REQ-026 SHALL, with rst high at a clock edge, force state=IDLE, index=0, shadow=16'h0000, stall counter=0, regardless of start or ongoing readout.
REQ-027 SHALL hold all outputs at reset value: busy=0, nib_valid=0, nib_last=0, nib_out=4'h0, done=0, err=0.
REQ-028 SHALL give rst priority over start and over a pending handshake in the same cycle.

Configuration
REQ-029 SHALL support macro WORD_NIBBLE_READER_LSB_FIRST_EN: when defined, emission order is shadow[3:0], [7:4], [11:8], [15:12]; when undefined, MSB-first per REQ-019. Handshake, timing and nib_last unchanged.

Verification
REQ-030 SHALL cover: in=16'hA5C3, start 1 cycle, nib_ready=1 constant -> nib_out A,5,C,3 on 4 consecutive cycles, nib_last with 3, done pulse next cycle, busy 4 cycles.
REQ-031 SHALL cover: in=16'h1234, nib_ready low 3 cycles on nibble 2 -> nib_out holds 2 stable, sequence 1,2,3,4 completes, total busy 7 cycles.
REQ-032 SHALL cover: start with in=16'hBEEF, then start with in=16'h0000 during SEND -> output B,E,E,F; second start ignored, busy returns low after done.
REQ-033 SHALL cover: rst asserted after 2nd nibble transfer -> next cycle busy=0, nib_valid=0, nib_out=0; new start with 16'h5A5A emits 5,A,5,A.
REQ-034 SHALL cover: TIMEOUT=4, nib_ready=0 after start -> err pulses once after 4 stalled cycles, done never asserted, busy=0.
REQ-035 SHALL cover: WORD_NIBBLE_READER_LSB_FIRST_EN defined, in=16'hA5C3 -> nib_out 3,C,5,A, nib_last with A.
